mprj_wb_core_mux: RTL and testbench
===================================

Name: mprj_wb_core_mux

Overview:
- Multi-core successor to the single-core user-project wrapper.
- Accepts the management SoC Wishbone slave bus and decodes it to NUM_CORES downstream Wishbone master ports plus a local control/status window.
- Adds per-core software reset, a bus timeout with error response, and selection of which core owns the user IO pads.
- Sits in the user project wrapper between the management bus and NUM_CORES core instances.

Parameters:
- NUM_CORES, 4, number of downstream cores (1..8)
- IO_PADS, 38, user IO pad count
- BASE_ADDR, 8'h30, required value of wbs_adr_i[31:24]
- TIMEOUT, 255, downstream wait cycles before error response (1..65535)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  asynchronous reset, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  management Wishbone controls
- wbs_sel_i  in  4  byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  address, write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- m_cyc_o, m_stb_o  out  NUM_CORES each  per-core cyc/stb
- m_we_o  out  1  shared write enable
- m_sel_o  out  4  shared byte selects
- m_adr_o, m_dat_o  out  32 each  shared address, write data
- m_ack_i  in  NUM_CORES  per-core ack
- m_dat_i  in  NUM_CORES*32  per-core read data; core k at [32k+31:32k]
- core_rst_o  out  NUM_CORES  per-core software reset
- core_io_out_i, core_io_oeb_i  in  NUM_CORES*IO_PADS each  per-core pad drive, pad enable
- io_out, io_oeb  out  IO_PADS each  pad outputs

Behaviour:
- Reset (async, wb_rst_i=1): state IDLE; wbs_ack_o=0; wbs_dat_o=0; all m_cyc_o/m_stb_o=0; m_adr_o, m_dat_o, m_sel_o, m_we_o=0; CTRL.core_rst=all 1s; CTRL.io_sel=0; STATUS=0.
- Decode (IDLE, cyc&stb, adr[31:24]==BASE_ADDR):
  - adr[23:20]=k<NUM_CORES: core window.
  - adr[23:20]=4'hF: local registers.
  - Any other address: unmapped.
- IDLE -> FWD (core window):
  - Next cycle m_cyc_o[k]=m_stb_o[k]=1.
  - m_adr_o={12'h0,adr[19:0]}.
  - m_dat_o, m_sel_o, m_we_o registered from the slave bus.
  - Timeout counter cleared.
- FWD:
  - m_ack_i[k]=1: capture m_dat_i slice k into wbs_dat_o (reads only, else 0); drop m_cyc_o/m_stb_o same edge; go RESP.
  - Counter reaches TIMEOUT with no ack: wbs_dat_o=32'hDEAD_BEEF; STATUS.to=1; STATUS.to_core=k; drop m_cyc_o/m_stb_o; go RESP.
  - Ack and timeout in the same cycle: ack wins.
  - wbs_cyc_i falls: abort; drop m_cyc_o/m_stb_o; go IDLE; no ack.
- IDLE -> RESP (local): register access performed; read data loaded into wbs_dat_o.
- IDLE -> RESP (unmapped): wbs_dat_o=0; writes discarded.
- RESP: wbs_ack_o=1 for exactly one cycle, then IDLE. wbs_dat_o holds until the next response.
- Latency:
  - Local/unmapped: request cycle N gives ack at N+1.
  - Core: core ack at cycle C gives slave ack at C+1.
- Local registers (adr[7:2]); unlisted offsets read 0, ignore writes:
  - 0x00 CTRL (RW, byte-enabled):
    - [NUM_CORES-1:0] core_rst, drives core_rst_o directly.
    - [11:8] io_sel.
  - 0x04 STATUS:
    - [0] to, sticky, write-1-to-clear.
    - [10:8] to_core, RO.
    - A timeout in the same cycle as a clear write leaves to=1.
  - 0x08 ID (RO): {8'h53, 8'(NUM_CORES), 16'h0002}.
- Writes to a core held in core_rst are still forwarded (the core may time out).
- IO mux (combinational):
  - io_sel<NUM_CORES: io_out/io_oeb = core_io_out_i/core_io_oeb_i slice io_sel.
  - Otherwise io_out=0, io_oeb=all 1s (pads tristated).
  - During reset io_sel=0, so core 0 owns the pads.
- Async reset mid-transaction: all strobes drop immediately; no ack is issued.

Test Plan:
- Reset, then read 0x30F0_0008 -> ack one cycle after stb; data 0x5304_0002. Read 0x30F0_0000 -> 0x0000_000F.
- Write 0x30F0_0000 = 0x0000_0205 with sel=4'b0011 -> core_rst_o=4'b0101; io_out equals core 2 slice. Write io_sel=7 -> io_out=0, io_oeb all 1s.
- Read 0x3020_0010, core 2 acks 3 cycles after strobe with 0x1234_5678 -> m_adr_o=0x0000_0010; m_stb_o=4'b0100; wbs_dat_o=0x1234_5678; wbs_ack_o one cycle after core ack.
- Access core 1 with no ack, TIMEOUT=255 -> ack after 255 wait cycles with 0xDEAD_BEEF; STATUS reads 0x0000_0101. Write 1 to STATUS[0] -> STATUS reads 0x0000_0100.
- Access 0x3050_0000 (k=5 >= NUM_CORES) or 0x3100_0000 -> single-cycle ack, data 0, no m_stb_o asserted.
- Drop wbs_cyc_i during FWD; separately, assert wb_rst_i during FWD -> m_stb_o low next edge (immediately under reset); no wbs_ack_o; next access completes normally.

Source files
------------

// File: rtl/mprj_wb_core_mux_if.sv
`default_nettype none
// ============================================================================
// mprj_wb_core_mux_if : management Wishbone slave bus plus per-core master bus
// Revision: 1.0
// ============================================================================
interface mprj_wb_core_mux_if #(
  parameter int NUM_CORES = 4
);
  logic                      wbs_cyc_i;
  logic                      wbs_stb_i;
  logic                      wbs_we_i;
  logic [3:0]                wbs_sel_i;
  logic [31:0]               wbs_adr_i;
  logic [31:0]               wbs_dat_i;
  logic                      wbs_ack_o;
  logic [31:0]               wbs_dat_o;
  logic [NUM_CORES-1:0]      m_cyc_o;
  logic [NUM_CORES-1:0]      m_stb_o;
  logic                      m_we_o;
  logic [3:0]                m_sel_o;
  logic [31:0]               m_adr_o;
  logic [31:0]               m_dat_o;
  logic [NUM_CORES-1:0]      m_ack_i;
  logic [NUM_CORES*32-1:0]   m_dat_i;

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    input  m_ack_i, m_dat_i
  );

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
    output m_ack_i, m_dat_i
  );
endinterface
`default_nettype wire

// File: rtl/mprj_wb_core_mux.sv
`default_nettype none
// ============================================================================
// mprj_wb_core_mux : Wishbone decode to NUM_CORES cores, local CSRs, IO pad mux
// Revision: 1.0
// ============================================================================
module mprj_wb_core_mux #(
  parameter int         NUM_CORES = 4,
  parameter int         IO_PADS   = 38,
  parameter logic [7:0] BASE_ADDR = 8'h30,
  parameter int         TIMEOUT   = 255
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  mprj_wb_core_mux_if.slave              bus,
  output logic [NUM_CORES-1:0]           core_rst_o,
  input  logic [NUM_CORES*IO_PADS-1:0]   core_io_out_i,
  input  logic [NUM_CORES*IO_PADS-1:0]   core_io_oeb_i,
  output logic [IO_PADS-1:0]             io_out,
  output logic [IO_PADS-1:0]             io_oeb
);

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, RESP = 2'd2} state_t;

  state_t               state;
  logic [2:0]           cur_core;
  logic [15:0]          cnt;
  logic [NUM_CORES-1:0] core_rst;
  logic [3:0]           io_sel;
  logic                 to_flag;
  logic [2:0]           to_core;

  logic        req;
  logic        base_ok;
  logic [3:0]  win;
  logic        core_hit;
  logic        local_hit;
  logic        core_ack;
  logic [31:0] core_rdata;
  logic [31:0] local_rdata;

  assign req       = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign base_ok   = (bus.wbs_adr_i[31:24] == BASE_ADDR);
  assign win       = bus.wbs_adr_i[23:20];
  assign core_hit  = base_ok && (win < 4'(NUM_CORES));
  assign local_hit = base_ok && (win == 4'hF);
  assign core_rst_o = core_rst;

  always_comb begin
    core_ack   = 1'b0;
    core_rdata = '0;
    io_out     = '0;
    io_oeb     = '1;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (cur_core == 3'(k)) begin
        core_ack   = bus.m_ack_i[k];
        core_rdata = bus.m_dat_i[k*32 +: 32];
      end
      if (io_sel == 4'(k)) begin
        io_out = core_io_out_i[k*IO_PADS +: IO_PADS];
        io_oeb = core_io_oeb_i[k*IO_PADS +: IO_PADS];
      end
    end
  end

  always_comb begin
    local_rdata = '0;
    case (bus.wbs_adr_i[7:2])
      6'h00:   local_rdata = {20'h0, io_sel, 8'(core_rst)};
      6'h01:   local_rdata = {21'h0, to_core, 7'h0, to_flag};
      6'h02:   local_rdata = {8'h53, 8'(NUM_CORES), 16'h0002};
      default: local_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      cur_core      <= '0;
      cnt           <= '0;
      core_rst      <= '1;
      io_sel        <= '0;
      to_flag       <= 1'b0;
      to_core       <= '0;
      bus.wbs_ack_o <= 1'b0;
      bus.wbs_dat_o <= '0;
      bus.m_cyc_o   <= '0;
      bus.m_stb_o   <= '0;
      bus.m_we_o    <= 1'b0;
      bus.m_sel_o   <= '0;
      bus.m_adr_o   <= '0;
      bus.m_dat_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.wbs_ack_o <= 1'b0;
          if (req) begin
            if (core_hit) begin
              state       <= FWD;
              cur_core    <= win[2:0];
              cnt         <= '0;
              bus.m_cyc_o <= NUM_CORES'(1) << win;
              bus.m_stb_o <= NUM_CORES'(1) << win;
              bus.m_adr_o <= {12'h0, bus.wbs_adr_i[19:0]};
              bus.m_dat_o <= bus.wbs_dat_i;
              bus.m_sel_o <= bus.wbs_sel_i;
              bus.m_we_o  <= bus.wbs_we_i;
            end else begin
              state         <= RESP;
              bus.wbs_ack_o <= 1'b1;
              bus.wbs_dat_o <= '0;
              if (local_hit && !bus.wbs_we_i) begin
                bus.wbs_dat_o <= local_rdata;
              end
              if (local_hit && bus.wbs_we_i) begin
                if (bus.wbs_adr_i[7:2] == 6'h00) begin
                  if (bus.wbs_sel_i[0]) core_rst <= bus.wbs_dat_i[NUM_CORES-1:0];
                  if (bus.wbs_sel_i[1]) io_sel   <= bus.wbs_dat_i[11:8];
                end
                if (bus.wbs_adr_i[7:2] == 6'h01 && bus.wbs_sel_i[0] && bus.wbs_dat_i[0]) begin
                  to_flag <= 1'b0;
                end
              end
            end
          end
        end
        FWD: begin
          // Master abort beats everything; core ack beats a coincident timeout.
          if (!bus.wbs_cyc_i) begin
            state       <= IDLE;
            bus.m_cyc_o <= '0;
            bus.m_stb_o <= '0;
          end else if (core_ack) begin
            state         <= RESP;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= bus.m_we_o ? 32'h0 : core_rdata;
            bus.m_cyc_o   <= '0;
            bus.m_stb_o   <= '0;
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            state         <= RESP;
            bus.wbs_ack_o <= 1'b1;
            bus.wbs_dat_o <= 32'hDEAD_BEEF;
            to_flag       <= 1'b1;
            to_core       <= cur_core;
            bus.m_cyc_o   <= '0;
            bus.m_stb_o   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          bus.wbs_ack_o <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.wbs_ack_o <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mprj_wb_core_mux.sv
`default_nettype none
// ============================================================================
// tb_mprj_wb_core_mux : randomized self-checking bench with a transaction model
// Revision: 1.0
// ============================================================================
module tb_mprj_wb_core_mux;
  localparam int NC = 4;
  localparam int IOP = 38;
  localparam int TMO = 255;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NC-1:0]     core_rst_o;
  logic [NC*IOP-1:0] core_io_out, core_io_oeb;
  logic [IOP-1:0]    io_out, io_oeb;

  int checks = 0;
  int errors = 0;

  // Reference state of the control/status registers
  logic [3:0] exp_core_rst;
  logic [3:0] exp_io_sel;
  logic       exp_to;
  logic [2:0] exp_to_core;

  // Observations returned by an access
  logic [31:0] rd, ma, md;
  logic [3:0]  stb, ms;
  logic        mw;
  int          lat;

  always #5 clk = ~clk;

  mprj_wb_core_mux_if #(.NUM_CORES(NC)) bus ();

  mprj_wb_core_mux #(.NUM_CORES(NC), .IO_PADS(IOP), .BASE_ADDR(8'h30), .TIMEOUT(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .bus(bus), .core_rst_o(core_rst_o),
    .core_io_out_i(core_io_out), .core_io_oeb_i(core_io_oeb),
    .io_out(io_out), .io_oeb(io_oeb)
  );

  task automatic rand_pads();
    for (int i = 0; i < NC*IOP; i++) begin
      core_io_out[i] = 1'($urandom_range(0, 1));
      core_io_oeb[i] = 1'($urandom_range(0, 1));
    end
  endtask

  // One complete master transaction; core k acks d cycles after the strobe appears.
  task automatic access(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                        input logic [3:0] sel, input int k, input int d, input logic [31:0] cdata);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    for (int i = 0; i < NC; i++) bus.m_dat_i[i*32 +: 32] = $urandom;
    lat = -1; rd = '0; stb = '0; ma = '0; md = '0; ms = '0; mw = 1'b0;
    for (int i = 1; i <= TMO + 10; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        lat = i; rd = bus.wbs_dat_o;
        break;
      end
      if (stb == 4'h0 && bus.m_stb_o != 4'h0) begin
        ma = bus.m_adr_o; md = bus.m_dat_o; ms = bus.m_sel_o; mw = bus.m_we_o;
      end
      stb = stb | bus.m_stb_o;
      bus.m_ack_i = '0;
      if (k >= 0 && i == d) begin
        bus.m_ack_i[k] = 1'b1;
        bus.m_dat_i[k*32 +: 32] = cdata;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.m_ack_i = '0;
  endtask

  function automatic logic [IOP-1:0] exp_pad_out();
    return (exp_io_sel < NC) ? core_io_out[int'(exp_io_sel)*IOP +: IOP] : '0;
  endfunction
  function automatic logic [IOP-1:0] exp_pad_oeb();
    return (exp_io_sel < NC) ? core_io_oeb[int'(exp_io_sel)*IOP +: IOP] : '1;
  endfunction

  task automatic test_reset();
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
    bus.wbs_adr_i = 0; bus.wbs_dat_i = 0; bus.m_ack_i = 0; bus.m_dat_i = 0;
    rand_pads();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    exp_core_rst = 4'hF; exp_io_sel = 0; exp_to = 0; exp_to_core = 0;
    checks++;
    if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin
      errors++; $display("FAIL reset_slave ack=%b dat=%h want 0/0", bus.wbs_ack_o, bus.wbs_dat_o);
    end
    checks++;
    if (bus.m_cyc_o !== 4'h0 || bus.m_stb_o !== 4'h0 || bus.m_adr_o !== 32'h0 ||
        bus.m_dat_o !== 32'h0 || bus.m_sel_o !== 4'h0 || bus.m_we_o !== 1'b0) begin
      errors++; $display("FAIL reset_master cyc=%h stb=%h adr=%h want all zero", bus.m_cyc_o, bus.m_stb_o, bus.m_adr_o);
    end
    checks++;
    if (core_rst_o !== exp_core_rst) begin
      errors++; $display("FAIL reset_core_rst got %b want %b", core_rst_o, exp_core_rst);
    end
    checks++;
    if (io_out !== exp_pad_out() || io_oeb !== exp_pad_oeb()) begin
      errors++; $display("FAIL reset_io_mux got %h/%h want %h/%h", io_out, io_oeb, exp_pad_out(), exp_pad_oeb());
    end
    rst = 1'b0;
  endtask

  task automatic test_local_regs();
    access(32'h30F0_0008, 0, 0, 4'hF, -1, 0, 0);
    checks++;
    if (rd !== 32'h5304_0002 || lat !== 1 || stb !== 4'h0) begin
      errors++; $display("FAIL id_read got %h lat %0d stb %b want 53040002 lat 1 stb 0", rd, lat, stb);
    end
    access(32'h30F0_0000, 0, 0, 4'hF, -1, 0, 0);
    checks++;
    if (rd !== 32'h0000_000F || lat !== 1) begin
      errors++; $display("FAIL ctrl_reset_read got %h lat %0d want 0000000f lat 1", rd, lat);
    end
    access(32'h30F0_0000, 1, 32'h0000_0205, 4'b0011, -1, 0, 0);
    exp_core_rst = 4'h5; exp_io_sel = 4'd2;
    @(negedge clk);
    checks++;
    if (core_rst_o !== 4'b0101 || io_out !== exp_pad_out() || io_oeb !== exp_pad_oeb()) begin
      errors++; $display("FAIL ctrl_write_205 core_rst %b io %h want %b %h", core_rst_o, io_out, exp_core_rst, exp_pad_out());
    end
    access(32'h30F0_0000, 1, 32'h0000_0700, 4'b0010, -1, 0, 0);
    exp_io_sel = 4'd7;
    @(negedge clk);
    checks++;
    if (io_out !== '0 || io_oeb !== '1 || core_rst_o !== exp_core_rst) begin
      errors++; $display("FAIL io_sel_7 io_out %h io_oeb %h want 0 / all ones", io_out, io_oeb);
    end
  endtask

  task automatic test_random_ctrl();
    for (int n = 0; n < 8; n++) begin
      logic [31:0] d;
      logic [3:0]  s;
      d = $urandom; s = 4'($urandom);
      rand_pads();
      access(32'h30F0_0000, 1, d, s, -1, 0, 0);
      if (s[0]) exp_core_rst = d[3:0];
      if (s[1]) exp_io_sel = d[11:8];
      access(32'h30F0_0000, 0, 0, 4'hF, -1, 0, 0);
      checks++;
      if (rd !== {20'h0, exp_io_sel, 4'h0, exp_core_rst} || core_rst_o !== exp_core_rst ||
          io_out !== exp_pad_out() || io_oeb !== exp_pad_oeb()) begin
        errors++; $display("FAIL rand_ctrl[%0d] rd %h rst %b io %h want %h %b %h", n, rd, core_rst_o,
                           io_out, {20'h0, exp_io_sel, 4'h0, exp_core_rst}, exp_core_rst, exp_pad_out());
      end
    end
  endtask

  task automatic test_core_read();
    access(32'h3020_0010, 0, 0, 4'hF, 2, 3, 32'h1234_5678);
    checks++;
    if (ma !== 32'h0000_0010 || stb !== 4'b0100) begin
      errors++; $display("FAIL core2_fwd adr %h stb %b want 00000010 0100", ma, stb);
    end
    checks++;
    if (rd !== 32'h1234_5678 || lat !== 4) begin
      errors++; $display("FAIL core2_resp dat %h lat %0d want 12345678 lat 4", rd, lat);
    end
  endtask

  task automatic test_random_core();
    for (int n = 0; n < 16; n++) begin
      int k, d;
      logic we;
      logic [31:0] adr, dat, cd, exp_rd;
      logic [3:0] sel;
      k = $urandom_range(0, NC-1); d = $urandom_range(1, 8); we = 1'($urandom_range(0, 1));
      adr = {8'h30, 4'(k), 20'($urandom)}; dat = $urandom; cd = $urandom; sel = 4'($urandom);
      exp_rd = we ? 32'h0 : cd;
      access(adr, we, dat, sel, k, d, cd);
      checks++;
      if (stb !== 4'(1 << k) || ma !== {12'h0, adr[19:0]} || md !== dat || ms !== sel || mw !== we) begin
        errors++; $display("FAIL rand_fwd[%0d] stb %b adr %h dat %h sel %h we %b want %b %h %h %h %b",
                           n, stb, ma, md, ms, mw, 4'(1 << k), {12'h0, adr[19:0]}, dat, sel, we);
      end
      checks++;
      if (rd !== exp_rd || lat !== d + 1) begin
        errors++; $display("FAIL rand_resp[%0d] dat %h lat %0d want %h lat %0d", n, rd, lat, exp_rd, d + 1);
      end
    end
  endtask

  task automatic test_timeout();
    access(32'h3010_0040, 0, 0, 4'hF, 1, 100000, 32'h0);
    exp_to = 1; exp_to_core = 3'd1;
    checks++;
    if (rd !== 32'hDEAD_BEEF || lat !== TMO + 1 || stb !== 4'b0010) begin
      errors++; $display("FAIL timeout dat %h lat %0d stb %b want deadbeef lat %0d 0010", rd, lat, stb, TMO + 1);
    end
    access(32'h30F0_0004, 0, 0, 4'hF, -1, 0, 0);
    checks++;
    if (rd !== {21'h0, exp_to_core, 7'h0, exp_to}) begin
      errors++; $display("FAIL status_after_to got %h want %h", rd, {21'h0, exp_to_core, 7'h0, exp_to});
    end
    access(32'h30F0_0004, 1, 32'h0000_0001, 4'hF, -1, 0, 0);
    exp_to = 0;
    access(32'h30F0_0004, 0, 0, 4'hF, -1, 0, 0);
    checks++;
    if (rd !== 32'h0000_0100) begin
      errors++; $display("FAIL status_w1c got %h want 00000100", rd);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] adrs [3];
    adrs[0] = 32'h3050_0000; adrs[1] = 32'h3100_0000; adrs[2] = 32'h30E0_0000;
    for (int n = 0; n < 3; n++) begin
      access(adrs[n], 1'(n == 2), 32'hFFFF_FFFF, 4'hF, -1, 0, 0);
      checks++;
      if (rd !== 32'h0 || lat !== 1 || stb !== 4'h0) begin
        errors++; $display("FAIL unmapped[%0d] dat %h lat %0d stb %b want 0 lat 1 stb 0", n, rd, lat, stb);
      end
    end
    access(32'h30F0_0000, 0, 0, 4'hF, -1, 0, 0);
    checks++;
    if (rd !== {20'h0, exp_io_sel, 4'h0, exp_core_rst}) begin
      errors++; $display("FAIL unmapped_write_discard ctrl %h want %h", rd, {20'h0, exp_io_sel, 4'h0, exp_core_rst});
    end
  endtask

  task automatic test_abort();
    int acks;
    @(negedge clk);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h3030_0000;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.m_stb_o !== 4'b1000) begin
      errors++; $display("FAIL abort_fwd stb %b want 1000", bus.m_stb_o);
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    acks = 0;
    @(negedge clk);
    checks++;
    if (bus.m_stb_o !== 4'h0 || bus.m_cyc_o !== 4'h0) begin
      errors++; $display("FAIL abort_drop stb %b cyc %b want 0", bus.m_stb_o, bus.m_cyc_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (bus.wbs_ack_o) acks++;
      @(negedge clk);
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL abort_no_ack acks %0d want 0", acks);
    end
    access(32'h30F0_0008, 0, 0, 4'hF, -1, 0, 0);
    checks++;
    if (rd !== 32'h5304_0002 || lat !== 1) begin
      errors++; $display("FAIL after_abort dat %h lat %0d want 53040002 lat 1", rd, lat);
    end
  endtask

  task automatic test_reset_mid_fwd();
    @(negedge clk);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h3000_0020;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.m_stb_o !== 4'b0001) begin
      errors++; $display("FAIL rstmid_fwd stb %b want 0001", bus.m_stb_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.m_stb_o !== 4'h0 || bus.m_cyc_o !== 4'h0 || bus.wbs_ack_o !== 1'b0 || core_rst_o !== 4'hF) begin
      errors++; $display("FAIL rstmid_async stb %b cyc %b ack %b core_rst %b want 0 0 0 1111",
                         bus.m_stb_o, bus.m_cyc_o, bus.wbs_ack_o, core_rst_o);
    end
    @(negedge clk);
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    rst = 1'b0;
    exp_core_rst = 4'hF; exp_io_sel = 0; exp_to = 0; exp_to_core = 0;
    access(32'h30F0_0004, 0, 0, 4'hF, -1, 0, 0);
    checks++;
    if (rd !== 32'h0 || lat !== 1) begin
      errors++; $display("FAIL rstmid_status dat %h lat %0d want 0 lat 1", rd, lat);
    end
    access(32'h3030_0004, 0, 0, 4'hF, 3, 2, 32'hCAFE_0003);
    checks++;
    if (rd !== 32'hCAFE_0003 || lat !== 3 || io_out !== exp_pad_out()) begin
      errors++; $display("FAIL rstmid_next dat %h lat %0d want cafe0003 lat 3", rd, lat);
    end
  endtask

  initial begin
    test_reset();
    test_local_regs();
    test_random_ctrl();
    test_core_read();
    test_random_core();
    test_timeout();
    test_unmapped();
    test_abort();
    test_reset_mid_fwd();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
